pattern_gen_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit pattern generator (LFSR / Sierpinski row engine) behind the top-level uo_out.
- Loads the generator seed.
- Issues single or counted steps at a programmable rate.
- Captures each new generator value into a valid-qualified output register.
- Sits between the ui_in/uio_in command decode and the generator instance.

---
 rtl/pattern_gen_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pattern_gen_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_ctrl.sv
// Command sequencer for the 8-bit pattern generator: seed load, single/counted
// stepping at a programmable rate, and a two-stage capture of generator output.
module pattern_gen_ctrl #(
  parameter int         DIV_W        = 8,
  parameter int         CNT_W        = 8,
  parameter logic [7:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             gen_load,
  output logic [7:0]       gen_seed,
  output logic             gen_step,
  input  logic [7:0]       gen_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  localparam logic [1:0] OP_ABORT = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STEP  = 2'b11;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       SEED_ZERO = 8'h00;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       seed_q, seed_d;
  logic             done_q, done_d;
  logic             step_d1_q, step_d1_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             cmd_accept_s;
  logic             step_raw_s;

  // Strobes and handshake are gated by ena so a frozen block is silent
  always_comb begin
    step_raw_s   = ((state_q == S_RUN) && (pre_q == DIV_ZERO)) || (state_q == S_STEP);
    cmd_ready    = ena && ((state_q == S_IDLE) || (state_q == S_RUN));
    cmd_accept_s = cmd_valid && cmd_ready;
    gen_step     = ena && step_raw_s;
    gen_load     = ena && (state_q == S_LOAD);
    gen_seed     = seed_q;
    out_data     = out_data_q;
    out_valid    = ena && out_valid_q;
    done         = ena && done_q;
    busy         = (state_q != S_IDLE);
  end

  // Next-state, counters and capture pipeline
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    div_d       = div_q;
    rem_d       = rem_q;
    seed_d      = seed_q;
    done_d      = 1'b0;
    // Stage 1 remembers a step; stage 2 samples the already-advanced generator
    step_d1_d   = gen_step;
    out_valid_d = step_d1_q;
    if (step_d1_q) begin
      out_data_d = gen_data;
    end else begin
      out_data_d = out_data_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_accept_s) begin
          case (cmd_op)
            OP_LOAD: begin
              // A zero seed would lock up an LFSR, so substitute the default
              if (cmd_arg[7:0] == SEED_ZERO) begin
                seed_d = DEFAULT_SEED;
              end else begin
                seed_d = cmd_arg[7:0];
              end
              state_d = S_LOAD;
            end
            OP_RUN: begin
              if (cmd_arg == CNT_ZERO) begin
                done_d = 1'b1;
              end else begin
                rem_d   = cmd_arg;
                div_d   = div_cfg;
                pre_d   = div_cfg;
                state_d = S_RUN;
              end
            end
            OP_STEP: begin
              state_d = S_STEP;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        // Abort wins over a coincident final step: a step still happens, but no done
        if (cmd_accept_s && (cmd_op == OP_ABORT)) begin
          state_d = S_IDLE;
          pre_d   = DIV_ZERO;
          rem_d   = CNT_ZERO;
        end else if (pre_q == DIV_ZERO) begin
          pre_d = div_q;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          pre_d = pre_q - DIV_ONE;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; every flop holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= DIV_ZERO;
      div_q       <= DIV_ZERO;
      rem_q       <= CNT_ZERO;
      seed_q      <= DEFAULT_SEED;
      done_q      <= 1'b0;
      step_d1_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      seed_q      <= seed_d;
      done_q      <= done_d;
      step_d1_q   <= step_d1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen_ctrl.sv
// Scenario bench for pattern_gen_ctrl with an LFSR generator model and a
// scoreboard of expected captured values.
module tb_pattern_gen_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] div_cfg;
  logic       gen_load;
  logic [7:0] gen_seed;
  logic       gen_step;
  logic [7:0] gen_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;

  int total;
  int bad;

  logic [7:0]  sb[$];
  logic [7:0]  model_val;
  logic [7:0]  exp_v;
  logic [7:0]  load_seed;
  logic [31:0] step_m, done_m, busy_m, load_m, valid_m, ready_m;
  logic        ready_at_send;

  pattern_gen_ctrl #(.DIV_W(8), .CNT_W(8), .DEFAULT_SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .div_cfg(div_cfg),
    .gen_load(gen_load), .gen_seed(gen_seed), .gen_step(gen_step),
    .gen_data(gen_data), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Generator model: loads on gen_load, advances on gen_step
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_data <= 8'h01;
    else if (gen_load) gen_data <= gen_seed;
    else if (gen_step) gen_data <= lfsr_next(gen_data);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic clear_masks();
    step_m = 32'h0; done_m = 32'h0; busy_m = 32'h0;
    load_m = 32'h0; valid_m = 32'h0; ready_m = 32'h0;
  endtask

  // Records cycle k at the falling edge and pops the scoreboard on out_valid
  task automatic sample(input int k);
    @(negedge clk);
    step_m[k]  = gen_step;
    done_m[k]  = done;
    busy_m[k]  = busy;
    load_m[k]  = gen_load;
    valid_m[k] = out_valid;
    ready_m[k] = cmd_ready;
    if (gen_load) load_seed = gen_seed;
    if (rst_n && out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: cycle %0d out_data=%02h, no value expected", k, out_data);
      end else begin
        exp_v = sb.pop_front();
        if (out_data !== exp_v) begin
          bad++;
          $display("FAIL sb_data: cycle %0d out_data=%02h expected %02h", k, out_data, exp_v);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int n);
    clear_masks();
    for (int k = 1; k <= n; k++) sample(k);
  endtask

  task automatic drive_cmd(input logic v, input logic [1:0] op, input logic [7:0] arg,
                           input logic [7:0] dv);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; div_cfg = dv;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] arg, input logic [7:0] dv);
    drive_cmd(1'b1, op, arg, dv);
    @(negedge clk);
    ready_at_send = cmd_ready;
    @(posedge clk);
    #1;
    drive_cmd(1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic push_steps(input int n);
    for (int i = 0; i < n; i++) begin
      model_val = lfsr_next(model_val);
      sb.push_back(model_val);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1;
    drive_cmd(1'b0, 2'b00, 8'h00, 8'h00);
    #12;
    total++;
    if (gen_seed !== 8'h01) begin
      bad++; $display("FAIL reset_seed: gen_seed=%02h expected 01", gen_seed);
    end
    total++;
    if (out_data !== 8'h00) begin
      bad++; $display("FAIL reset_out: out_data=%02h expected 00", out_data);
    end
    total++;
    if ({busy, done, out_valid, gen_step, gen_load} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: %b expected 00000", {busy, done, out_valid, gen_step, gen_load});
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_val = 8'h01;
  endtask

  task automatic test_load_seed();
    send(2'b01, 8'h00, 8'h00);
    load_seed = 8'h00;
    observe(3);
    total++;
    if (ready_at_send !== 1'b1) begin
      bad++; $display("FAIL load0_ready: cmd_ready=%b expected 1", ready_at_send);
    end
    total++;
    if ({load_m, busy_m, done_m, step_m} !== {32'h2, 32'h2, 32'h0, 32'h0}) begin
      bad++; $display("FAIL load0_masks: load=%h busy=%h done=%h step=%h expected 2 2 0 0",
                      load_m, busy_m, done_m, step_m);
    end
    total++;
    if (load_seed !== 8'h01) begin
      bad++; $display("FAIL load0_seed: gen_seed=%02h expected 01", load_seed);
    end
    send(2'b01, 8'hA5, 8'h00);
    observe(3);
    model_val = 8'hA5;
    total++;
    if ({load_m, busy_m, valid_m} !== {32'h2, 32'h2, 32'h0}) begin
      bad++; $display("FAIL loadA5_masks: load=%h busy=%h valid=%h expected 2 2 0", load_m, busy_m, valid_m);
    end
    total++;
    if (load_seed !== 8'hA5) begin
      bad++; $display("FAIL loadA5_seed: gen_seed=%02h expected a5", load_seed);
    end
  endtask

  task automatic test_run_fast();
    send(2'b01, 8'h00, 8'h00);
    observe(2);
    model_val = 8'h01;
    send(2'b10, 8'd4, 8'd0);
    push_steps(4);
    observe(8);
    total++;
    if ({step_m, done_m, busy_m, valid_m} !== {32'h1E, 32'h20, 32'h1E, 32'h78}) begin
      bad++; $display("FAIL run4_masks: step=%h done=%h busy=%h valid=%h expected 1e 20 1e 78",
                      step_m, done_m, busy_m, valid_m);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL run4_sb_left: %0d values pending, expected 0", sb.size());
    end
  endtask

  task automatic test_run_div();
    send(2'b10, 8'd3, 8'd2);
    push_steps(3);
    observe(12);
    total++;
    if ({step_m, done_m, busy_m, valid_m} !== {32'h248, 32'h400, 32'h3FE, 32'h920}) begin
      bad++; $display("FAIL run3_masks: step=%h done=%h busy=%h valid=%h expected 248 400 3fe 920",
                      step_m, done_m, busy_m, valid_m);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL run3_sb_left: %0d values pending, expected 0", sb.size());
    end
  endtask

  task automatic test_abort();
    send(2'b10, 8'd10, 8'd1);
    push_steps(2);
    clear_masks();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) drive_cmd(1'b1, 2'b10, 8'd5, 8'd0);
      else if (k == 4) drive_cmd(1'b1, 2'b00, 8'h00, 8'h00);
      else drive_cmd(1'b0, 2'b00, 8'h00, 8'h00);
      sample(k);
    end
    drive_cmd(1'b0, 2'b00, 8'h00, 8'h00);
    total++;
    if ({step_m, done_m, busy_m, valid_m} !== {32'h14, 32'h0, 32'h1E, 32'h50}) begin
      bad++; $display("FAIL abort_masks: step=%h done=%h busy=%h valid=%h expected 14 0 1e 50",
                      step_m, done_m, busy_m, valid_m);
    end
    total++;
    if (ready_m !== 32'h1FE) begin
      bad++; $display("FAIL abort_ready: ready=%h expected 1fe", ready_m);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL abort_sb_left: %0d values pending, expected 0", sb.size());
    end
  endtask

  task automatic test_ena_freeze();
    send(2'b11, 8'h00, 8'h00);
    push_steps(1);
    clear_masks();
    sample(1);
    ena = 1'b0;
    for (int k = 2; k <= 6; k++) sample(k);
    ena = 1'b1;
    for (int k = 7; k <= 10; k++) sample(k);
    total++;
    if ({step_m, done_m, busy_m, valid_m} !== {32'h2, 32'h80, 32'h2, 32'h100}) begin
      bad++; $display("FAIL freeze_masks: step=%h done=%h busy=%h valid=%h expected 2 80 2 100",
                      step_m, done_m, busy_m, valid_m);
    end
    total++;
    if (ready_m !== 32'h780) begin
      bad++; $display("FAIL freeze_ready: ready=%h expected 780", ready_m);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL freeze_sb_left: %0d values pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    send(2'b10, 8'd10, 8'd0);
    push_steps(10);
    observe(3);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_val = 8'h01;
    #1;
    total++;
    if ({busy, done, out_valid, gen_step, gen_load} !== 5'b0) begin
      bad++; $display("FAIL midrst_flags: %b expected 00000", {busy, done, out_valid, gen_step, gen_load});
    end
    total++;
    if ({gen_seed, out_data} !== {8'h01, 8'h00}) begin
      bad++; $display("FAIL midrst_regs: seed=%02h out=%02h expected 01 00", gen_seed, out_data);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    observe(3);
    total++;
    if ({step_m, done_m, busy_m, valid_m} !== 128'h0) begin
      bad++; $display("FAIL postrst_masks: step=%h done=%h busy=%h valid=%h expected all 0",
                      step_m, done_m, busy_m, valid_m);
    end
    total++;
    if (gen_seed !== 8'h01) begin
      bad++; $display("FAIL postrst_seed: gen_seed=%02h expected 01", gen_seed);
    end
    send(2'b10, 8'd0, 8'd3);
    observe(3);
    total++;
    if ({step_m, done_m, busy_m} !== {32'h0, 32'h2, 32'h0}) begin
      bad++; $display("FAIL run0_masks: step=%h done=%h busy=%h expected 0 2 0", step_m, done_m, busy_m);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load_seed();
    test_run_fast();
    test_run_div();
    test_abort();
    test_ena_freeze();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
